ibuf_queue_ctrl: RTL and testbench

//  Instruction-buffer controller between IFU and decode. Accepts a fetch group of
//  Cfg.INSTR_PER_FETCH ibuf_entry_t slots, compacts the valid slots, and queues them
//  in program order in a circular buffer. Presents up to DEC_W oldest entries per cycle
//  to decode and flushes on frontend redirect.

---
 rtl/ibuf_queue_ctrl_pkg.sv | 34 +++
 rtl/ibuf_compact.sv | 24 ++
 rtl/ibuf_queue_ctrl.sv | 120 ++++++++++++
 tb/tb_ibuf_queue_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ibuf_queue_ctrl_pkg.sv
// Shared types and build-time configuration for the instruction-buffer queue.
// Provides ibuf_entry_t, the handshake type and the Cfg constant set.
package ibuf_queue_ctrl_pkg;

  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned IBUF_DEPTH;
    int unsigned DEC_WIDTH;
  } cfg_t;

  function automatic cfg_t build_config();
    cfg_t c;
    c.INSTR_PER_FETCH = 4;
    c.IBUF_DEPTH      = 16;
    c.DEC_WIDTH       = 4;
    return c;
  endfunction

  localparam cfg_t Cfg = build_config();

  typedef struct packed {
    logic        slot_valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_entry_t;

  localparam int ENTRY_W = $bits(ibuf_entry_t);

  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

endpackage

// File: rtl/ibuf_compact.sv
// Combinational prefix sum over fetch-slot valid bits: each live slot gets its
// write offset from the queue tail, and n_enq is the total number of live slots.
module ibuf_compact #(
  parameter int FETCH_W = 4,
  parameter int CNT_W   = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]            slot_valid,
  output logic [FETCH_W-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]              n_enq
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(slot_valid[i]);
    end
    n_enq = acc;
  end

endmodule

// File: rtl/ibuf_queue_ctrl.sv
// Instruction-buffer queue between fetch and decode: compacts fetch groups into a
// circular buffer and presents the oldest entries to decode. Optional perf counters
// are built when IBUF_PERF_CNT_EN is defined.
module ibuf_queue_ctrl
  import ibuf_queue_ctrl_pkg::*;
#(
  parameter int DEPTH   = Cfg.IBUF_DEPTH,
  parameter int FETCH_W = Cfg.INSTR_PER_FETCH,
  parameter int DEC_W   = Cfg.DEC_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         fe_valid_i,
  output logic                         fe_ready_o,
  input  logic [FETCH_W*ENTRY_W-1:0]   fe_entries_i,
  output logic [DEC_W-1:0]             de_valid_o,
  output logic [DEC_W*ENTRY_W-1:0]     de_entries_o,
  input  logic [$clog2(DEC_W+1)-1:0]   de_accept_i,
  output logic [$clog2(DEPTH):0]       count_o
`ifdef IBUF_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_fe_stall_o,
  output logic [31:0]                  perf_de_empty_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACC_W = $clog2(DEC_W + 1);
  localparam int NE_W  = $clog2(FETCH_W + 1);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_next;
  ibuf_entry_t      mem [DEPTH];

  ibuf_entry_t                   fe_ent [FETCH_W];
  logic [FETCH_W-1:0]            slot_valid;
  logic [FETCH_W-1:0][NE_W-1:0]  offset;
  logic [NE_W-1:0]               n_enq, n_enq_eff;
  logic [ACC_W-1:0]              n_deq;
  logic                          enq_fire;

  // Saturate the decode accept count to the number of entries actually presented.
  function automatic logic [ACC_W-1:0] clamp_deq(input logic [ACC_W-1:0] req,
                                                  input logic [CNT_W-1:0] cnt);
    logic [ACC_W-1:0] avail;
    avail = (cnt > CNT_W'(DEC_W)) ? ACC_W'(DEC_W) : ACC_W'(cnt);
    return (req > avail) ? avail : req;
  endfunction

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      fe_ent[i]     = fe_entries_i[i*ENTRY_W +: ENTRY_W];
      slot_valid[i] = fe_ent[i].slot_valid;
    end
  end

  ibuf_compact #(.FETCH_W(FETCH_W), .CNT_W(NE_W)) u_compact (
    .slot_valid (slot_valid),
    .offset     (offset),
    .n_enq      (n_enq)
  );

  // Ready looks only at the registered count, so a same-cycle dequeue never raises it.
  assign fe_ready_o = (count <= CNT_W'(DEPTH - FETCH_W));
  assign enq_fire   = fe_valid_i & fe_ready_o;
  assign n_enq_eff  = enq_fire ? n_enq : '0;
  assign n_deq      = clamp_deq(de_accept_i, count);
  assign count_next = count + CNT_W'(n_enq_eff) - CNT_W'(n_deq);
  assign count_o    = count;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(n_enq_eff);
      head  <= head + PTR_W'(n_deq);
      count <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (enq_fire && !flush_i && !rst_i && slot_valid[i])
        mem[tail + PTR_W'(offset[i])] <= fe_ent[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && count != '0)
      assert (de_accept_i <= n_deq);
  end

  // Read lanes are indexed from the registered head; pointer arithmetic wraps naturally.
  always_comb begin
    logic [PTR_W-1:0] rd_idx;
    de_entries_o = '0;
    for (int i = 0; i < DEC_W; i++) begin
      rd_idx                              = head + PTR_W'(i);
      de_valid_o[i]                       = (count > CNT_W'(i));
      de_entries_o[i*ENTRY_W +: ENTRY_W]  = mem[rd_idx];
    end
  end

`ifdef IBUF_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fe_stall_o <= '0;
      perf_de_empty_o <= '0;
    end else begin
      if (fe_valid_i && !fe_ready_o) perf_fe_stall_o <= perf_fe_stall_o + 32'd1;
      if (count == '0)               perf_de_empty_o <= perf_de_empty_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ibuf_queue_ctrl.sv
// Directed bench for ibuf_queue_ctrl: hand-computed vectors covering enqueue
// compaction, full/ready behaviour, pointer wrap, flush, reset and perf counters.
module tb_ibuf_queue_ctrl;
  import ibuf_queue_ctrl_pkg::*;

  localparam int FW    = Cfg.INSTR_PER_FETCH;
  localparam int DW    = Cfg.DEC_WIDTH;
  localparam int DEPTH = Cfg.IBUF_DEPTH;

  logic                     clk = 1'b0;
  logic                     rst_i, flush_i, fe_valid_i, fe_ready_o;
  logic [FW*ENTRY_W-1:0]    fe_entries_i;
  logic [DW-1:0]            de_valid_o;
  logic [DW*ENTRY_W-1:0]    de_entries_o;
  logic [$clog2(DW+1)-1:0]  de_accept_i;
  logic [$clog2(DEPTH):0]   count_o;
`ifdef IBUF_PERF_CNT_EN
  logic [31:0]              perf_fe_stall_o, perf_de_empty_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ibuf_queue_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .fe_valid_i   (fe_valid_i),
    .fe_ready_o   (fe_ready_o),
    .fe_entries_i (fe_entries_i),
    .de_valid_o   (de_valid_o),
    .de_entries_o (de_entries_o),
    .de_accept_i  (de_accept_i),
    .count_o      (count_o)
`ifdef IBUF_PERF_CNT_EN
    ,
    .perf_fe_stall_o (perf_fe_stall_o),
    .perf_de_empty_o (perf_de_empty_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW*ENTRY_W-1:0] grp(input logic [31:0] base, input logic [FW-1:0] sv);
    logic [FW*ENTRY_W-1:0] g;
    ibuf_entry_t e;
    g = '0;
    for (int i = 0; i < FW; i++) begin
      e.slot_valid = sv[i];
      e.pc         = base + 32'(4 * i);
      e.instr      = ~e.pc;
      g[i*ENTRY_W +: ENTRY_W] = e;
    end
    return g;
  endfunction

  function automatic logic [31:0] lane_pc(input int i);
    ibuf_entry_t e;
    e = de_entries_o[i*ENTRY_W +: ENTRY_W];
    return e.pc;
  endfunction

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; fe_valid_i = 1'b0; de_accept_i = '0;
    fe_entries_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ready", 64'(fe_ready_o), 64'd1);
    chk("rst_de_valid", 64'(de_valid_o), 64'd0);

    // Full group of four
    fe_valid_i = 1'b1; fe_entries_i = grp(32'h8000_0000, 4'b1111);
    tick();
    fe_valid_i = 1'b0;
    chk("g1_de_valid", 64'(de_valid_o), 64'hF);
    chk("g1_lane0_pc", 64'(lane_pc(0)), 64'h8000_0000);
    chk("g1_lane3_pc", 64'(lane_pc(3)), 64'h8000_000C);
    chk("g1_count", 64'(count_o), 64'd4);

    // Sparse group, slots 1 and 3
    fe_valid_i = 1'b1; fe_entries_i = grp(32'h8000_0010, 4'b1010);
    tick();
    fe_valid_i = 1'b0;
    chk("g2_count", 64'(count_o), 64'd6);
    de_accept_i = 3'd4;
    tick();
    de_accept_i = '0;
    chk("g2_count_after_deq", 64'(count_o), 64'd2);
    chk("g2_de_valid", 64'(de_valid_o), 64'h3);
    chk("g2_lane0_pc", 64'(lane_pc(0)), 64'h8000_0014);
    chk("g2_lane1_pc", 64'(lane_pc(1)), 64'h8000_001C);

    // Flush with simultaneous enqueue and dequeue
    flush_i = 1'b1; fe_valid_i = 1'b1; de_accept_i = 3'd2;
    fe_entries_i = grp(32'h7000_0000, 4'b1111);
    tick();
    flush_i = 1'b0; fe_valid_i = 1'b0; de_accept_i = '0;
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_de_valid", 64'(de_valid_o), 64'd0);
    chk("fl_ready", 64'(fe_ready_o), 64'd1);
    fe_valid_i = 1'b1; fe_entries_i = grp(32'h9000_0000, 4'b1111);
    tick();
    chk("fl_new_count", 64'(count_o), 64'd4);
    chk("fl_new_lane0", 64'(lane_pc(0)), 64'h9000_0000);

    // Fill to full
    fe_entries_i = grp(32'h9000_0010, 4'b1111); tick();
    fe_entries_i = grp(32'h9000_0020, 4'b1111); tick();
    chk("fill12_ready", 64'(fe_ready_o), 64'd1);
    fe_entries_i = grp(32'h9000_0030, 4'b1111); tick();
    chk("fill16_count", 64'(count_o), 64'd16);
    chk("fill16_ready", 64'(fe_ready_o), 64'd0);
    fe_entries_i = grp(32'h9000_0040, 4'b1111); tick();
    chk("full_hold_count", 64'(count_o), 64'd16);
    de_accept_i = 3'd2; tick();
    chk("full14_count", 64'(count_o), 64'd14);
    chk("full14_ready", 64'(fe_ready_o), 64'd0);
    chk("full14_lane0", 64'(lane_pc(0)), 64'h9000_0008);
    tick();
    fe_valid_i = 1'b0;
    chk("full12_count", 64'(count_o), 64'd12);
    chk("full12_ready", 64'(fe_ready_o), 64'd1);

    // Drain to head=12, then enqueue 2 while dequeuing 2: head=14, count=4
    de_accept_i = 3'd4; tick(); tick();
    chk("drain_count", 64'(count_o), 64'd4);
    fe_valid_i = 1'b1; fe_entries_i = grp(32'h9000_0040, 4'b0011); de_accept_i = 3'd2;
    tick();
    fe_valid_i = 1'b0; de_accept_i = '0;
    chk("wrap_count", 64'(count_o), 64'd4);
    chk("wrap_de_valid", 64'(de_valid_o), 64'hF);
    chk("wrap_lane0", 64'(lane_pc(0)), 64'h9000_0038);
    chk("wrap_lane1", 64'(lane_pc(1)), 64'h9000_003C);
    chk("wrap_lane2", 64'(lane_pc(2)), 64'h9000_0040);
    chk("wrap_lane3", 64'(lane_pc(3)), 64'h9000_0044);
    de_accept_i = 3'd4; tick();
    chk("wrap_drain_count", 64'(count_o), 64'd0);
    chk("wrap_drain_valid", 64'(de_valid_o), 64'd0);

    // Accept while empty is ignored
    de_accept_i = 3'd3; tick();
    de_accept_i = '0;
    chk("empty_acc_count", 64'(count_o), 64'd0);

    // Head now 2: new group lands in order
    fe_valid_i = 1'b1; fe_entries_i = grp(32'hA000_0000, 4'b1111); tick();
    chk("h2_count", 64'(count_o), 64'd4);
    chk("h2_lane0", 64'(lane_pc(0)), 64'hA000_0000);
    chk("h2_lane3", 64'(lane_pc(3)), 64'hA000_000C);
    fe_entries_i = grp(32'hB000_0000, 4'b0000); tick();
    fe_valid_i = 1'b0;
    chk("zero_grp_count", 64'(count_o), 64'd4);
    chk("zero_grp_lane0", 64'(lane_pc(0)), 64'hA000_0000);

    // Mid-operation reset
    rst_i = 1'b1; tick();
    chk("mrst_count", 64'(count_o), 64'd0);
    chk("mrst_ready", 64'(fe_ready_o), 64'd1);
    chk("mrst_de_valid", 64'(de_valid_o), 64'd0);
`ifdef IBUF_PERF_CNT_EN
    chk("perf_rst_stall", 64'(perf_fe_stall_o), 64'd0);
    chk("perf_rst_empty", 64'(perf_de_empty_o), 64'd0);
    rst_i = 1'b0;
    fe_valid_i = 1'b1; fe_entries_i = grp(32'hC000_0000, 4'b1111);
    for (int i = 0; i < 7; i++) tick();
    fe_valid_i = 1'b0;
    de_accept_i = 3'd4;
    for (int i = 0; i < 4; i++) tick();
    de_accept_i = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("perf_stall", 64'(perf_fe_stall_o), 64'd3);
    chk("perf_empty", 64'(perf_de_empty_o), 64'd5);
`endif
    rst_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
